// File: rtl/pwr_rst_pkg.sv
// Shared types and constants for the power-on reset generator.
package pwr_rst_pkg;

  typedef enum logic [0:0] {
    StAssert   = 1'b0,
    StReleased = 1'b1
  } pwr_rst_state_e;

  localparam int unsigned ResetCyclesDefault = 16;
  localparam int unsigned RstCountW          = 8;

endpackage

// File: rtl/power_on_reset_gen_if.sv
// Output bundle of the power-on reset generator.
// rst_count is present only when PWR_RST_COUNT_EN is defined.
interface power_on_reset_gen_if;
  import pwr_rst_pkg::*;

  logic rst_out;
  logic done;
`ifdef PWR_RST_COUNT_EN
  logic [RstCountW-1:0] rst_count;

  modport master (output rst_out, output done, output rst_count);
  modport slave  (input rst_out, input done, input rst_count);
`else
  modport master (output rst_out, output done);
  modport slave  (input rst_out, input done);
`endif

endinterface

// File: rtl/power_on_reset_gen.sv
// Power-on reset generator: holds rst_out for RESET_CYCLES edges after power-up or rst.
// Optional sequence counter output enabled by PWR_RST_COUNT_EN.
module power_on_reset_gen
  import pwr_rst_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = ResetCyclesDefault,
  localparam int unsigned CNT_W       = $clog2(RESET_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  power_on_reset_gen_if.master bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(RESET_CYCLES - 1);

  // No reset exists at power-up, so state comes from register initial values.
  pwr_rst_state_e   state_q   = StAssert;
  pwr_rst_state_e   state_d;
  logic [CNT_W-1:0] cnt_q     = '0;
  logic [CNT_W-1:0] cnt_d;
  logic             rst_out_q = 1'b1;
  logic             rst_out_d;
  logic             done_q    = 1'b0;
  logic             done_d;
  logic             release_evt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_out_d   = rst_out_q;
    done_d      = done_q;
    release_evt = 1'b0;
    if (rst) begin
      state_d   = StAssert;
      cnt_d     = '0;
      rst_out_d = 1'b1;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == CntLast) begin
            state_d     = StReleased;
            rst_out_d   = 1'b0;
            done_d      = 1'b1;
            release_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StReleased: ;
        default: begin
          state_d   = StAssert;
          cnt_d     = '0;
          rst_out_d = 1'b1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    rst_out_q <= rst_out_d;
    done_q    <= done_d;
  end

  assign bus.rst_out = rst_out_q;
  assign bus.done    = done_q;

`ifdef PWR_RST_COUNT_EN
  // Survives rst so software can see how many reset sequences have completed.
  logic [RstCountW-1:0] rst_count_q = '0;

  always_ff @(posedge clk) begin
    if (release_evt && (rst_count_q != '1)) begin
      rst_count_q <= rst_count_q + 1'b1;
    end
  end

  assign bus.rst_count = rst_count_q;
`endif

endmodule

// File: tb/tb_power_on_reset_gen.sv
// Scoreboard bench for power_on_reset_gen: a 16-cycle and a 1-cycle instance share rst.
module tb_power_on_reset_gen;

  typedef struct {
    bit ro16;
    bit ro1;
    int c16;
    int c1;
  } exp_t;

  logic clk = 1'b1;
  logic rst = 1'b0;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   prev16   = 1'b1;
  bit   prev1    = 1'b1;
  int   cnt16    = 0;
  int   cnt1     = 0;

  power_on_reset_gen_if bus16 ();
  power_on_reset_gen_if bus1 ();

  power_on_reset_gen #(.RESET_CYCLES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  power_on_reset_gen #(.RESET_CYCLES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Push the outputs expected after the next rising edge.
  task automatic push_exp(input bit ro16, input bit ro1);
    exp_t e;
    if (prev16 && !ro16 && cnt16 < 255) cnt16++;
    if (prev1 && !ro1 && cnt1 < 255) cnt1++;
    prev16 = ro16;
    prev1  = ro1;
    e.ro16 = ro16;
    e.ro1  = ro1;
    e.c16  = cnt16;
    e.c1   = cnt1;
    q.push_back(e);
  endtask

  // The 1-cycle instance releases on the first edge with rst low, so it simply follows rst.
  task automatic seq(input int n, input bit r, input bit ro16);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      push_exp(ro16, r);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rst_out16", int'(bus16.rst_out), int'(e.ro16));
      chk("done16", int'(bus16.done), int'(!e.ro16));
      chk("rst_out1", int'(bus1.rst_out), int'(e.ro1));
      chk("done1", int'(bus1.done), int'(!e.ro1));
`ifdef PWR_RST_COUNT_EN
      chk("rst_count16", int'(bus16.rst_count), e.c16);
      chk("rst_count1", int'(bus1.rst_count), e.c1);
`endif
    end
  end

  initial begin
    exp_t e0;
    // Power-up state before any edge.
    e0.ro16 = 1'b1;
    e0.ro1  = 1'b1;
    e0.c16  = 0;
    e0.c1   = 0;
    q.push_back(e0);

    // Power-up: high through edge 15, low from edge 16 for 100+ cycles.
    seq(15, 1'b0, 1'b1);
    seq(101, 1'b0, 1'b0);

    // Single-cycle rst pulse.
    seq(1, 1'b1, 1'b1);
    seq(15, 1'b0, 1'b1);
    seq(10, 1'b0, 1'b0);

    // rst held 10 cycles in RELEASED.
    seq(10, 1'b1, 1'b1);
    seq(15, 1'b0, 1'b1);
    seq(10, 1'b0, 1'b0);

    // rst re-asserted at count 8 of a running sequence: no partial credit.
    seq(1, 1'b1, 1'b1);
    seq(8, 1'b0, 1'b1);
    seq(3, 1'b1, 1'b1);
    seq(15, 1'b0, 1'b1);
    seq(10, 1'b0, 1'b0);

    // 300 further sequences drive rst_count into saturation.
    for (int k = 0; k < 300; k++) begin
      seq(1, 1'b1, 1'b1);
      seq(15, 1'b0, 1'b1);
      seq(1, 1'b0, 1'b0);
    end
    seq(5, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
